// File: rtl/alu_pkg.sv
// Shared ALU definitions: the function-code enum, the NOP alias and the
// legality check. Decode, issue and the ALU itself all import this package.
package alu_pkg;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'b00001,
        ALU_SUB  = 5'b00010,
        ALU_SLL  = 5'b00011,
        ALU_SLT  = 5'b00100,
        ALU_SLTU = 5'b00101,
        ALU_SRL  = 5'b00110,
        ALU_SRA  = 5'b00111,
        ALU_LUI  = 5'b01000,
        ALU_XOR  = 5'b01001,
        ALU_OR   = 5'b01010,
        ALU_AND  = 5'b01011
    } alu_op_e;

    localparam alu_op_e ALU_NOP = ALU_ADD;

    // Legal codes form the contiguous range 1..11.
    function automatic logic is_legal_alu_op(input logic [4:0] f);
        return (f >= 5'd1) && (f <= 5'd11);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Priority operand select for one source register:
// x0 -> 0, then EX/MEM match, then MEM/WB match, then register-file data.
// o_hit flags a forward-path match so a held operand can be refreshed.
module fwd_select #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter bit FWD_EN     = 1'b1
) (
    input  logic [REG_ADDR_W-1:0] i_addr,
    input  logic [XLEN-1:0]       i_rf_data,
    input  logic                  i_exmem_we,
    input  logic [REG_ADDR_W-1:0] i_exmem_rd,
    input  logic [XLEN-1:0]       i_exmem_data,
    input  logic                  i_memwb_we,
    input  logic [REG_ADDR_W-1:0] i_memwb_rd,
    input  logic [XLEN-1:0]       i_memwb_data,
    output logic [XLEN-1:0]       o_data,
    output logic                  o_hit
);

    logic w_nonzero;
    logic w_ex_hit;
    logic w_wb_hit;

    assign w_nonzero = |i_addr;
    assign w_ex_hit  = FWD_EN && w_nonzero && i_exmem_we && (i_exmem_rd == i_addr);
    assign w_wb_hit  = FWD_EN && w_nonzero && i_memwb_we && (i_memwb_rd == i_addr);
    assign o_hit     = w_ex_hit || w_wb_hit;

    // Newest producer wins; x0 is hard-wired to zero.
    always_comb begin
        o_data = i_rf_data;
        if (!w_nonzero)
            o_data = '0;
        else if (w_ex_hit)
            o_data = i_exmem_data;
        else if (w_wb_hit)
            o_data = i_memwb_data;
    end

endmodule

// File: rtl/id_ex_issue.sv
// ID/EX issue register: captures a decoded instruction, sanitises the ALU
// code, forwards operands and presents one registered entry to execute.
// Build option ID_EX_FORWARDING_EN enables EX/MEM and MEM/WB forwarding and
// the refresh of held operands during a stall; without it operands come
// straight from the register file (x0 still reads as zero).
module id_ex_issue
    import alu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4:0]            in_alu_function,
    input  logic [REG_ADDR_W-1:0] in_rs1_addr,
    input  logic [REG_ADDR_W-1:0] in_rs2_addr,
    input  logic [XLEN-1:0]       in_rs1_data,
    input  logic [XLEN-1:0]       in_rs2_data,
    input  logic [XLEN-1:0]       in_imm,
    input  logic                  in_use_imm,
    input  logic [REG_ADDR_W-1:0] in_rd_addr,
    input  logic                  in_reg_write,
    input  logic                  flush,
    input  logic                  ex_ready,
    input  logic                  exmem_reg_write,
    input  logic [REG_ADDR_W-1:0] exmem_rd_addr,
    input  logic [XLEN-1:0]       exmem_result,
    input  logic                  memwb_reg_write,
    input  logic [REG_ADDR_W-1:0] memwb_rd_addr,
    input  logic [XLEN-1:0]       memwb_result,
    output logic                  ex_valid,
    output logic [4:0]            alu_function,
    output logic [XLEN-1:0]       operand_a,
    output logic [XLEN-1:0]       operand_b,
    output logic [REG_ADDR_W-1:0] ex_rd_addr,
    output logic                  ex_reg_write,
    output logic                  illegal_op
);

`ifdef ID_EX_FORWARDING_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic                  r_ex_valid;
    alu_op_e               r_alu_function;
    logic [XLEN-1:0]       r_operand_a;
    logic [XLEN-1:0]       r_operand_b;
    logic [REG_ADDR_W-1:0] r_rd_addr;
    logic                  r_reg_write;
    logic                  r_illegal;
    logic [REG_ADDR_W-1:0] r_rs1_addr;
    logic [REG_ADDR_W-1:0] r_rs2_addr;
    logic                  r_use_imm;

    logic                  w_holding;
    logic                  w_capture;
    logic                  w_alu_legal;
    alu_op_e               w_alu_code;
    logic [REG_ADDR_W-1:0] w_rs1_sel_addr;
    logic [REG_ADDR_W-1:0] w_rs2_sel_addr;
    logic [XLEN-1:0]       w_rs1_data;
    logic [XLEN-1:0]       w_rs2_data;
    logic                  w_rs1_hit;
    logic                  w_rs2_hit;

    assign w_holding = r_ex_valid && !ex_ready;
    assign in_ready  = !r_ex_valid || ex_ready;
    assign w_capture = in_valid && in_ready && !flush;

    assign w_alu_legal = is_legal_alu_op(in_alu_function);
    assign w_alu_code  = w_alu_legal ? alu_op_e'(in_alu_function) : ALU_NOP;

    // Capture and refresh never coincide (holding forces in_ready low), so
    // one selector per source serves both by switching to the stored address.
    assign w_rs1_sel_addr = w_holding ? r_rs1_addr : in_rs1_addr;
    assign w_rs2_sel_addr = w_holding ? r_rs2_addr : in_rs2_addr;

    fwd_select #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W), .FWD_EN(FWD_EN)) u_fwd_rs1 (
        .i_addr       (w_rs1_sel_addr),
        .i_rf_data    (in_rs1_data),
        .i_exmem_we   (exmem_reg_write),
        .i_exmem_rd   (exmem_rd_addr),
        .i_exmem_data (exmem_result),
        .i_memwb_we   (memwb_reg_write),
        .i_memwb_rd   (memwb_rd_addr),
        .i_memwb_data (memwb_result),
        .o_data       (w_rs1_data),
        .o_hit        (w_rs1_hit)
    );

    fwd_select #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W), .FWD_EN(FWD_EN)) u_fwd_rs2 (
        .i_addr       (w_rs2_sel_addr),
        .i_rf_data    (in_rs2_data),
        .i_exmem_we   (exmem_reg_write),
        .i_exmem_rd   (exmem_rd_addr),
        .i_exmem_data (exmem_result),
        .i_memwb_we   (memwb_reg_write),
        .i_memwb_rd   (memwb_rd_addr),
        .i_memwb_data (memwb_result),
        .o_data       (w_rs2_data),
        .o_hit        (w_rs2_hit)
    );

    // Entry validity: flush, then capture, then drain on ex_ready, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ex_valid <= 1'b0;
        else if (flush)
            r_ex_valid <= 1'b0;
        else if (w_capture)
            r_ex_valid <= 1'b1;
        else if (ex_ready)
            r_ex_valid <= 1'b0;
    end

    // Entry payload: load on capture, refresh forwarded operands while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_function <= ALU_NOP;
            r_operand_a    <= '0;
            r_operand_b    <= '0;
            r_rd_addr      <= '0;
            r_reg_write    <= 1'b0;
            r_illegal      <= 1'b0;
            r_rs1_addr     <= '0;
            r_rs2_addr     <= '0;
            r_use_imm      <= 1'b0;
        end else if (w_capture) begin
            r_alu_function <= w_alu_code;
            r_operand_a    <= w_rs1_data;
            r_operand_b    <= in_use_imm ? in_imm : w_rs2_data;
            r_rd_addr      <= in_rd_addr;
            r_reg_write    <= in_reg_write;
            r_illegal      <= !w_alu_legal;
            r_rs1_addr     <= in_rs1_addr;
            r_rs2_addr     <= in_rs2_addr;
            r_use_imm      <= in_use_imm;
        end else if (w_holding) begin
            if (w_rs1_hit)
                r_operand_a <= w_rs1_data;
            if (w_rs2_hit && !r_use_imm)
                r_operand_b <= w_rs2_data;
        end
    end

    // Write enable and illegal flag are qualified so they drop with ex_valid.
    assign ex_valid     = r_ex_valid;
    assign alu_function = r_alu_function;
    assign operand_a    = r_operand_a;
    assign operand_b    = r_operand_b;
    assign ex_rd_addr   = r_rd_addr;
    assign ex_reg_write = r_ex_valid && r_reg_write;
    assign illegal_op   = r_ex_valid && r_illegal;

endmodule

// File: tb/tb_id_ex_issue.sv
// Scoreboard bench for id_ex_issue: the driver pushes the expected entry when
// it offers an instruction; a monitor pops and compares whenever execute
// consumes an entry (ex_valid && ex_ready). Expected values follow the
// ID_EX_FORWARDING_EN build option.
module tb_id_ex_issue;

`ifdef ID_EX_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        logic [4:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        rw;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_alu_function = '0;
    logic [4:0]  in_rs1_addr = '0;
    logic [4:0]  in_rs2_addr = '0;
    logic [31:0] in_rs1_data = '0;
    logic [31:0] in_rs2_data = '0;
    logic [31:0] in_imm = '0;
    logic        in_use_imm = 1'b0;
    logic [4:0]  in_rd_addr = '0;
    logic        in_reg_write = 1'b0;
    logic        flush = 1'b0;
    logic        ex_ready = 1'b1;
    logic        exmem_reg_write = 1'b0;
    logic [4:0]  exmem_rd_addr = '0;
    logic [31:0] exmem_result = '0;
    logic        memwb_reg_write = 1'b0;
    logic [4:0]  memwb_rd_addr = '0;
    logic [31:0] memwb_result = '0;
    logic        ex_valid;
    logic [4:0]  alu_function;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [4:0]  ex_rd_addr;
    logic        ex_reg_write;
    logic        illegal_op;

    id_ex_issue #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_alu_function (in_alu_function),
        .in_rs1_addr     (in_rs1_addr),
        .in_rs2_addr     (in_rs2_addr),
        .in_rs1_data     (in_rs1_data),
        .in_rs2_data     (in_rs2_data),
        .in_imm          (in_imm),
        .in_use_imm      (in_use_imm),
        .in_rd_addr      (in_rd_addr),
        .in_reg_write    (in_reg_write),
        .flush           (flush),
        .ex_ready        (ex_ready),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd_addr   (exmem_rd_addr),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd_addr   (memwb_rd_addr),
        .memwb_result    (memwb_result),
        .ex_valid        (ex_valid),
        .alu_function    (alu_function),
        .operand_a       (operand_a),
        .operand_b       (operand_b),
        .ex_rd_addr      (ex_rd_addr),
        .ex_reg_write    (ex_reg_write),
        .illegal_op      (illegal_op)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] f, input logic [4:0] rs1, input logic [31:0] d1,
                         input logic [4:0] rs2, input logic [31:0] d2, input logic [4:0] rd,
                         input logic rw, input logic ui, input logic [31:0] imm);
        in_valid        = 1'b1;
        in_alu_function = f;
        in_rs1_addr     = rs1;
        in_rs1_data     = d1;
        in_rs2_addr     = rs2;
        in_rs2_data     = d2;
        in_rd_addr      = rd;
        in_reg_write    = rw;
        in_use_imm      = ui;
        in_imm          = imm;
    endtask

    task automatic push(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic rw, input logic ill);
        exp_t e;
        e.f = f; e.a = a; e.b = b; e.rd = rd; e.rw = rw; e.ill = ill;
        exp_q.push_back(e);
    endtask

    task automatic clear_fwd();
        exmem_reg_write = 1'b0; exmem_rd_addr = '0; exmem_result = '0;
        memwb_reg_write = 1'b0; memwb_rd_addr = '0; memwb_result = '0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, {31'd0, ex_valid}, 32'd0);
        chk({tag, "_func"},  {27'd0, alu_function}, 32'd1);
        chk({tag, "_opa"},   operand_a, 32'd0);
        chk({tag, "_opb"},   operand_b, 32'd0);
        chk({tag, "_rd"},    {27'd0, ex_rd_addr}, 32'd0);
        chk({tag, "_rw"},    {31'd0, ex_reg_write}, 32'd0);
        chk({tag, "_ill"},   {31'd0, illegal_op}, 32'd0);
    endtask

    // Monitor: every consumed entry must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && ex_valid && ex_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_entry: got func=%h a=%h b=%h expected none",
                             alu_function, operand_a, operand_b);
                end else begin
                    e = exp_q.pop_front();
                    chk("mon_func", {27'd0, alu_function}, {27'd0, e.f});
                    chk("mon_opa",  operand_a, e.a);
                    chk("mon_opb",  operand_b, e.b);
                    chk("mon_rd",   {27'd0, ex_rd_addr}, {27'd0, e.rd});
                    chk("mon_rw",   {31'd0, ex_reg_write}, {31'd0, e.rw});
                    chk("mon_ill",  {31'd0, illegal_op}, {31'd0, e.ill});
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        bad++;
        $display("FAIL timeout: got running expected finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    logic [4:0] ill_codes [6] = '{5'd15, 5'd9, 5'd0, 5'd12, 5'd11, 5'd31};
    logic [4:0] ill_expf  [6] = '{5'd1,  5'd9, 5'd1, 5'd1,  5'd11, 5'd1};
    logic       ill_expi  [6] = '{1'b1,  1'b0, 1'b1, 1'b1,  1'b0,  1'b1};

    initial begin
        exp_t dropped;

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        chk_reset("reset");
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        #20 rst_n = 1'b1;
        tick();

        // Plain ADD
        drive(5'd1, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 1'b1, 1'b0, 32'd0);
        push(5'd1, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0);
        tick();

        // EX/MEM and MEM/WB both match rs1: EX/MEM wins
        drive(5'd2, 5'd1, 32'd11, 5'd4, 32'd9, 5'd5, 1'b1, 1'b0, 32'd0);
        exmem_reg_write = 1'b1; exmem_rd_addr = 5'd1; exmem_result = 32'd100;
        memwb_reg_write = 1'b1; memwb_rd_addr = 5'd1; memwb_result = 32'd200;
        push(5'd2, FWD ? 32'd100 : 32'd11, 32'd9, 5'd5, 1'b1, 1'b0);
        tick();

        // rs1 = x0 with producers writing x0: still zero
        drive(5'd2, 5'd0, 32'd33, 5'd6, 32'd13, 5'd5, 1'b1, 1'b0, 32'd0);
        exmem_rd_addr = 5'd0; memwb_rd_addr = 5'd0;
        push(5'd2, 32'd0, 32'd13, 5'd5, 1'b1, 1'b0);
        tick();

        // MEM/WB feeds rs1, EX/MEM feeds rs2
        drive(5'd4, 5'd7, 32'd21, 5'd8, 32'd1, 5'd9, 1'b0, 1'b0, 32'd0);
        exmem_rd_addr = 5'd8; exmem_result = 32'd88;
        memwb_rd_addr = 5'd7; memwb_result = 32'd77;
        push(5'd4, FWD ? 32'd77 : 32'd21, FWD ? 32'd88 : 32'd1, 5'd9, 1'b0, 1'b0);
        tick();

        // Stall: I_A captured, then held three cycles while I_B waits
        clear_fwd();
        drive(5'd10, 5'd9, 32'd3, 5'd2, 32'd44, 5'd10, 1'b1, 1'b0, 32'd0);
        push(5'd10, 32'd3, FWD ? 32'd55 : 32'd44, 5'd10, 1'b1, 1'b0);
        tick();
        ex_ready = 1'b0;
        drive(5'd11, 5'd12, 32'd6, 5'd13, 32'd8, 5'd14, 1'b0, 1'b0, 32'd0);
        push(5'd11, 32'd6, 32'd8, 5'd14, 1'b0, 1'b0);
        #1;
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        chk("stall_func", {27'd0, alu_function}, 32'd10);
        chk("stall_opa", operand_a, 32'd3);
        chk("stall_opb", operand_b, 32'd44);
        tick();
        memwb_reg_write = 1'b1; memwb_rd_addr = 5'd2; memwb_result = 32'd55;
        chk("stall_opb_stable", operand_b, 32'd44);
        chk("stall_valid", {31'd0, ex_valid}, 32'd1);
        tick();
        clear_fwd();
        chk("refresh_opb", operand_b, FWD ? 32'd55 : 32'd44);
        chk("refresh_opa", operand_a, 32'd3);
        chk("stall_in_ready2", {31'd0, in_ready}, 32'd0);
        tick();
        ex_ready = 1'b1;
        #1;
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        tick();

        // Code legality sweep including range boundaries
        for (int i = 0; i < 6; i++) begin
            drive(ill_codes[i], 5'd3, 32'd100 + 32'(i), 5'd4, 32'd200 + 32'(i),
                  5'(i + 1), 1'b1, 1'b0, 32'd0);
            push(ill_expf[i], 32'd100 + 32'(i), 32'd200 + 32'(i), 5'(i + 1), 1'b1, ill_expi[i]);
            tick();
        end
        in_valid = 1'b0;
        tick();

        // Flush: held illegal entry and incoming instruction both dropped
        drive(5'd20, 5'd1, 32'd1, 5'd2, 32'd2, 5'd6, 1'b1, 1'b0, 32'd0);
        push(5'd1, 32'd1, 32'd2, 5'd6, 1'b1, 1'b1);
        tick();
        ex_ready = 1'b0;
        chk("preflush_ill", {31'd0, illegal_op}, 32'd1);
        chk("preflush_rw", {31'd0, ex_reg_write}, 32'd1);
        flush = 1'b1;
        drive(5'd3, 5'd1, 32'd1, 5'd2, 32'd2, 5'd7, 1'b1, 1'b0, 32'd0);
        dropped = exp_q.pop_back();
        tick();
        chk("flush_valid", {31'd0, ex_valid}, 32'd0);
        chk("flush_rw", {31'd0, ex_reg_write}, 32'd0);
        chk("flush_ill", {31'd0, illegal_op}, 32'd0);
        flush = 1'b0;
        in_valid = 1'b0;
        ex_ready = 1'b1;
        tick();
        chk("flush_dropped", {31'd0, ex_valid}, 32'd0);

        // Asynchronous reset while stalled with a waiting instruction
        drive(5'd2, 5'd1, 32'd9, 5'd2, 32'd8, 5'd8, 1'b1, 1'b0, 32'd0);
        push(5'd2, 32'd9, 32'd8, 5'd8, 1'b1, 1'b0);
        tick();
        ex_ready = 1'b0;
        drive(5'd3, 5'd4, 32'd4, 5'd5, 32'd5, 5'd9, 1'b1, 1'b0, 32'd0);
        tick();
        #1;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk_reset("async_reset");
        dropped = exp_q.pop_back();
        #1 rst_n = 1'b1;
        tick();

        // Immediate operand: no rs2 forward at capture nor refresh in stall
        ex_ready = 1'b1;
        drive(5'd1, 5'd1, 32'd4, 5'd2, 32'd99, 5'd9, 1'b1, 1'b1, 32'hFFFF_FFF0);
        exmem_reg_write = 1'b1; exmem_rd_addr = 5'd2; exmem_result = 32'd1234;
        push(5'd1, 32'd4, 32'hFFFF_FFF0, 5'd9, 1'b1, 1'b0);
        tick();
        ex_ready = 1'b0;
        in_valid = 1'b0;
        clear_fwd();
        memwb_reg_write = 1'b1; memwb_rd_addr = 5'd2; memwb_result = 32'd555;
        tick();
        tick();
        chk("imm_hold_opb", operand_b, 32'hFFFF_FFF0);
        clear_fwd();
        ex_ready = 1'b1;
        tick();
        tick();
        tick();

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
